// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer with one-entry holding register
module uart_rx_ctrl #(
    parameter int NB_DATA = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    input  logic               i_rd,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_frame_err,
    output logic               o_overrun
);

    localparam int S_MAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int S_W   = (S_MAX > 2) ? $clog2(S_MAX) : 1;
    localparam int N_W   = (NB_DATA > 2) ? $clog2(NB_DATA) : 1;

    localparam logic [S_W-1:0] S_MID  = S_W'(OVS / 2 - 1);
    localparam logic [S_W-1:0] S_BIT  = S_W'(OVS - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(NB_DATA - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [S_W-1:0]     s_q, s_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic               commit;
    logic               rx_meta, rx_s;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start bit.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (s_q == S_MID) begin
                        s_d = '0;
                        if (!rx_s) begin
                            state_d = DATA;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (s_q == S_BIT) begin
                        s_d     = '0;
                        shift_d = {rx_s, shift_q[NB_DATA-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (s_q == S_STOP) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
                n_d     = '0;
            end
        endcase
    end

    // A pop coinciding with a commit consumes the old word, so no overrun is flagged.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else if (commit) begin
            o_data      <= shift_q;
            o_valid     <= 1'b1;
            o_frame_err <= ~rx_s;
            if (i_rd) begin
                o_overrun <= 1'b0;
            end else if (o_valid) begin
                o_overrun <= 1'b1;
            end
        end else if (i_rd && o_valid) begin
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed vector bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    logic       i_clk;
    logic       i_reset;
    logic       i_tick = 1'b0;
    logic       i_rx;
    logic       i_rd;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;

    int n_checks = 0;
    int n_errors = 0;
    int tick_div = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       do_rd;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[5];

    uart_rx_ctrl #(
        .NB_DATA(8),
        .OVS    (16),
        .SB_TICK(16)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_tick     (i_tick),
        .i_rx       (i_rx),
        .i_rd       (i_rd),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // One tick every 10 clocks, changed on the falling edge.
    always @(negedge i_clk) begin
        tick_div = (tick_div == 9) ? 0 : tick_div + 1;
        i_tick   = (tick_div == 9);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ed, input logic ev,
                           input logic ef, input logic eo);
        chk({tag, ".data"}, o_data, ed);
        chk({tag, ".valid"}, {7'd0, o_valid}, {7'd0, ev});
        chk({tag, ".ferr"}, {7'd0, o_frame_err}, {7'd0, ef});
        chk({tag, ".ovr"}, {7'd0, o_overrun}, {7'd0, eo});
    endtask

    task automatic step();
        @(negedge i_clk);
        #1;
    endtask

    // Returns just after the clock edge that consumed the next tick.
    task automatic wait_tick();
        int guard;
        guard = 0;
        while (!i_tick && guard < 50) begin
            step();
            guard++;
        end
        if (!i_tick) begin
            n_checks++;
            n_errors++;
            $display("FAIL tick_timeout: got no tick within %0d cycles", guard);
        end
        step();
    endtask

    // Line level before relative tick t+1; stop level only held up to the stop sample.
    function automatic logic line_level(input logic [7:0] d, input logic stop, input int t);
        int b;
        b = t / 16;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (t <= 151) return stop;
        return 1'b1;
    endfunction

    task automatic drive_frame(input logic [7:0] d, input logic stop, input int nticks);
        wait_tick();
        for (int t = 0; t < nticks; t++) begin
            i_rx = line_level(d, stop, t);
            wait_tick();
        end
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h12, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h34, 1'b1, 1'b1, 8'h34, 1'b1, 1'b0, 1'b1};

        i_reset = 1'b1;
        i_rx    = 1'b1;
        i_rd    = 1'b0;
        repeat (3) step();
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        i_reset = 1'b0;
        step();

        for (int i = 0; i < 5; i++) begin
            drive_frame(vecs[i].data, vecs[i].stop, 160);
            i_rx = 1'b1;
            chk_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid,
                    vecs[i].exp_ferr, vecs[i].exp_ovr);
            if (vecs[i].do_rd) begin
                i_rd = 1'b1;
                step();
                i_rd = 1'b0;
                chk_out($sformatf("vec%0d_pop", i), vecs[i].exp_data, 1'b0,
                        vecs[i].exp_ferr, 1'b0);
            end
        end

        // Start glitch of 5 ticks, then a stray pop with nothing pending
        wait_tick();
        i_rx = 1'b0;
        repeat (5) wait_tick();
        i_rx = 1'b1;
        repeat (10) wait_tick();
        i_rd = 1'b1;
        step();
        i_rd = 1'b0;
        chk_out("glitch", 8'h34, 1'b0, 1'b0, 1'b0);
        drive_frame(8'h81, 1'b1, 160);
        chk_out("after_glitch", 8'h81, 1'b1, 1'b0, 1'b0);
        i_rd = 1'b1;
        step();
        i_rd = 1'b0;

        // Pop in the exact commit cycle of the next word
        drive_frame(8'h66, 1'b1, 160);
        chk_out("pend66", 8'h66, 1'b1, 1'b0, 1'b0);
        drive_frame(8'h77, 1'b1, 151);
        i_rx = 1'b1;
        while (!i_tick) step();
        i_rd = 1'b1;
        step();
        i_rd = 1'b0;
        chk_out("simul77", 8'h77, 1'b1, 1'b0, 1'b0);
        repeat (10) wait_tick();

        // Reset during data bit 4 of 0xF0
        drive_frame(8'hF0, 1'b1, 84);
        i_reset = 1'b1;
        #1;
        chk_out("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
        step();
        i_reset = 1'b0;
        i_rx    = 1'b1;
        repeat (100) wait_tick();
        chk("no_spurious_valid", {7'd0, o_valid}, 8'h00);
        drive_frame(8'h0F, 1'b1, 160);
        chk_out("after_reset", 8'h0F, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
